// File: rtl/ser_feed.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : ser_feed                                                 |
// | Description : Parallel-in / serial-out feeder. Words arrive over a     |
// |               valid/ready handshake and leave MSB-first, one bit per   |
// |               clock in which the downstream asserts bit_en.            |
// |               Optional macro SER_PRELOAD_EN adds a one-word holding    |
// |               register so consecutive words stream without a bubble.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module ser_feed #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             accept;
  logic             xfer;
  logic             last;

`ifdef SER_PRELOAD_EN
  logic [WIDTH-1:0] hold, hold_nx;
  logic             hold_full, hold_full_nx;

  // Room for a new word exists whenever the holding slot is empty.
  assign din_ready = rst & ~hold_full;
`else
  // Without a holding slot a new word fits only between words.
  assign din_ready = rst & (state == IDLE);
`endif

  assign out_valid = (state == SHIFT);
  assign busy      = (state == SHIFT);
  assign out_bit   = out_valid & sh[WIDTH-1];
  assign accept    = din_valid & din_ready;
  assign xfer      = out_valid & bit_en;
  assign last      = xfer & (cnt == '0);
  assign word_done = last;

  // Next-state and datapath decisions; every target defaults to hold.
  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    cnt_nx   = cnt;
`ifdef SER_PRELOAD_EN
    hold_nx      = hold;
    hold_full_nx = hold_full;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          sh_nx    = din;
          cnt_nx   = LAST_CNT;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
`ifdef SER_PRELOAD_EN
          // Chain straight into the next word when one is available.
          if (hold_full) begin
            sh_nx        = hold;
            cnt_nx       = LAST_CNT;
            hold_full_nx = 1'b0;
          end else if (accept) begin
            sh_nx  = din;
            cnt_nx = LAST_CNT;
          end else begin
            state_nx = IDLE;
          end
`else
          state_nx = IDLE;
`endif
        end else begin
          if (xfer) begin
            sh_nx  = {sh[WIDTH-2:0], 1'b0};
            cnt_nx = cnt - ONE_CNT;
          end
`ifdef SER_PRELOAD_EN
          if (accept) begin
            hold_nx      = din;
            hold_full_nx = 1'b1;
          end
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
`ifdef SER_PRELOAD_EN
      hold      <= '0;
      hold_full <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      sh    <= sh_nx;
      cnt   <= cnt_nx;
`ifdef SER_PRELOAD_EN
      hold      <= hold_nx;
      hold_full <= hold_full_nx;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/ser_feed.md
# ser_feed

Parallel-in/serial-out feeder that sits directly upstream of the sequence-detector FSMs. It accepts parallel words over a valid/ready handshake and emits them MSB-first, one bit per enabled clock. Its serial output drives the detector's `in` port. A downstream `bit_en` input paces the stream, so stalls never corrupt bit order.

## Interface

- `WIDTH`, 8, word length in bits; legal range WIDTH >= 2
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  synchronous reset, active-low
- `din`  in  WIDTH  parallel word to serialize
- `din_valid`  in  1  `din` holds a valid word
- `din_ready`  out  1  block accepts `din` this cycle
- `bit_en`  in  1  downstream consumes the current bit this cycle
- `out_bit`  out  1  serial bit; connects to the detector's `in`
- `out_valid`  out  1  `out_bit` is meaningful
- `busy`  out  1  a word is being shifted
- `word_done`  out  1  one-cycle pulse when the last bit of a word is consumed

## Operation

- Registers:
  - shift register `sh[WIDTH-1:0]`
  - bit counter `cnt`, width $clog2(WIDTH)
  - state in {IDLE, SHIFT}
- Accept: `din_valid & din_ready` at a rising edge.
- Transfer: `out_valid & bit_en` at a rising edge.
- IDLE:
  - `din_ready`=1 and `out_valid`=0.
  - On accept: `sh`<=`din`, `cnt`<=WIDTH-1, go to SHIFT.
- SHIFT:
  - `out_valid`=1, `busy`=1, `out_bit`=`sh[WIDTH-1]`.
  - On transfer with `cnt`!=0: `sh`<=`sh`<<1 (zero fill), `cnt`<=`cnt`-1.
  - On transfer with `cnt`==0: `word_done`=1 (combinational, same cycle), then go to IDLE unless a preload applies (see Configuration).
  - `bit_en`=0: everything holds; `out_bit` stays stable.
- `din_ready` is forced to 0 while `rst`=0.
- `din` is sampled only on accept, so later changes to `din` have no effect.
- `busy` = (state==SHIFT).
- `out_bit` = 0 whenever `out_valid`=0.
- Reset values (rst=0 at an edge):
  - state=IDLE, `sh`=0, `cnt`=0, holding register cleared
  - outputs `out_bit`=0, `out_valid`=0, `busy`=0, `word_done`=0, `din_ready`=0
- Reset mid-word: the partial word and any held word are discarded. Nothing resumes after release.

## Timing

- With accept at edge k and `bit_en`=1 continuously:
  - bit i (MSB first) is presented in cycle k+1+i, for i=0..WIDTH-1.
  - `word_done` is high in cycle k+WIDTH.
- Latency from accept to first bit: 1 cycle.
- Without the macro, back-to-back words have exactly one bubble cycle (`out_valid`=0, `din_ready`=1) between them.
- `bit_en` stalls stretch the timing cycle-for-cycle; no bits are lost or duplicated.
- `bit_en` while `out_valid`=0 is ignored.
- First cycle after reset release: `din_ready`=1, so an accept is possible at the next edge.

## Configuration

- `SER_PRELOAD_EN` defined adds a one-word holding register `hold` with flag `hold_full`:
  - `din_ready` = !`hold_full` (still 0 in reset).
  - Accept in IDLE loads `sh` directly.
  - Accept in SHIFT loads `hold`.
  - On the last-bit transfer:
    - if `hold_full`: `sh`<=`hold`, `cnt`<=WIDTH-1, stay in SHIFT, clear `hold_full`;
    - else if an accept happens the same cycle: `din` loads `sh` directly, stay in SHIFT;
    - else go to IDLE.
  - Back-to-back words therefore stream with zero bubble cycles.
- `SER_PRELOAD_EN` undefined: no holding register, and `din_ready`=1 only in IDLE.

## Test plan

- Reset:
  - Stimulus: `rst`=0 for 2 cycles with `din_valid`=1.
  - Response: during reset, `out_valid`=0, `out_bit`=0, `busy`=0, `din_ready`=0, and no word is accepted. First cycle after release: `din_ready`=1.
- Single word:
  - Stimulus: WIDTH=5, `din`=5'b10110, `bit_en`=1.
  - Response: `out_bit` = 1,0,1,1,0 on 5 consecutive cycles; `word_done` high on the 5th cycle. With the overlapping detector chained, its `out` pulses on the 5th bit.
- Stall:
  - Stimulus: WIDTH=5, `din`=5'b10110, `bit_en`=0 for 3 cycles after the 2nd bit.
  - Response: `out_bit` holds at 1 through the stall, the sequence resumes as 1,1,0, and total `out_valid` cycles = 8.
- Back-to-back:
  - Stimulus: words 5'b10110 then 5'b10110 with `din_valid` held.
  - Response without macro: 5 valid, 1 bubble, 5 valid.
  - Response with `SER_PRELOAD_EN`: 10 contiguous valid cycles, stream 1011010110, and the detector pulses twice.
- Backpressure:
  - Stimulus: `din_valid`=1 with a new `din` while SHIFT is in progress (macro off).
  - Response: `din_ready`=0; the word is accepted only in the IDLE cycle.
- Reset mid-word:
  - Stimulus: `rst`=0 after 2 bits of 5'b10110 (with a held word when the macro is on).
  - Response: after the edge, `out_valid`=0 and the held word is discarded. After release, a new word starts from its MSB.
